// File: rtl/pc_sequencer.sv
// Eight-phase instruction sequencer: fetches one- or two-word instructions, drives PC-stack ops and PC nibble writes.
// Optional feature: define PC_SEQ_JCN_EN to make JCN (opr 0x1) a two-word conditional page-local jump.
module pc_sequencer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       halt_req,
  input  logic [3:0] data,
  input  logic       cond,
  output logic [2:0] cycle,
  output logic       halt,
  output logic [1:0] control,
  output logic [1:0] pc_next_sel,
  output logic [2:0] pc_write_enable,
  output logic [3:0] inst_operand,
  output logic [3:0] opr,
  output logic [3:0] opa,
  output logic       stack_ovf,
  output logic       stack_unf
);

  localparam int unsigned NIB_W   = 4;
  localparam int unsigned CYC_W   = 3;
  localparam int unsigned CTL_W   = 2;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned WE_W    = 3;
  localparam int unsigned DEPTH_W = 2;

  localparam logic [CTL_W-1:0] CTRL_NOP  = CTL_W'(0);
  localparam logic [CTL_W-1:0] CTRL_PUSH = CTL_W'(1);
  localparam logic [CTL_W-1:0] CTRL_POP  = CTL_W'(2);

  localparam logic [SEL_W-1:0] PC_FROM_INC  = SEL_W'(0);
  localparam logic [SEL_W-1:0] PC_FROM_INST = SEL_W'(1);

  localparam logic [WE_W-1:0] WE_HI  = 3'b100;
  localparam logic [WE_W-1:0] WE_MID = 3'b010;
  localparam logic [WE_W-1:0] WE_LO  = 3'b001;

  localparam logic [NIB_W-1:0] OP_JCN = 4'h1;
  localparam logic [NIB_W-1:0] OP_JUN = 4'h4;
  localparam logic [NIB_W-1:0] OP_JMS = 4'h5;
  localparam logic [NIB_W-1:0] OP_BBL = 4'hC;

  typedef enum logic [1:0] {
    ST_FETCH1 = 2'd0,
    ST_FETCH2 = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  state_e               state_q,   state_d;
  logic [CYC_W-1:0]     cycle_q,   cycle_d;
  logic                 halt_q,    halt_d;
  logic [NIB_W-1:0]     opr_q,     opr_d;
  logic [NIB_W-1:0]     opa_q,     opa_d;
  logic [NIB_W-1:0]     w2_opr_q,  w2_opr_d;
  logic [NIB_W-1:0]     w2_opa_q,  w2_opa_d;
  logic                 cond_q,    cond_d;
  logic [DEPTH_W-1:0]   depth_q,   depth_d;
  logic                 ovf_q,     ovf_d;
  logic                 unf_q,     unf_d;
  logic [CTL_W-1:0]     ctrl_q,    ctrl_d;
  logic [SEL_W-1:0]     sel_q,     sel_d;
  logic [WE_W-1:0]      we_q,      we_d;
  logic [NIB_W-1:0]     operand_q, operand_d;

  logic is_jun;
  logic is_jms;
  logic is_jcn;
  logic is_bbl;
  logic two_word;
  logic full_jump;
  logic jcn_taken;
  logic cond_s;

  assign is_jun = (opr_q == OP_JUN);
  assign is_jms = (opr_q == OP_JMS);
  assign is_bbl = (opr_q == OP_BBL);

`ifdef PC_SEQ_JCN_EN
  assign is_jcn = (opr_q == OP_JCN);
  assign cond_s = cond;
`else
  logic unused_cond;
  assign is_jcn      = 1'b0;
  assign cond_s      = 1'b0;
  assign unused_cond = cond;
`endif

  assign two_word  = is_jun | is_jms | is_jcn;
  assign full_jump = is_jun | is_jms;
  assign jcn_taken = is_jcn & cond_q;

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_FETCH1;
      cycle_q   <= '0;
      halt_q    <= 1'b0;
      opr_q     <= '0;
      opa_q     <= '0;
      w2_opr_q  <= '0;
      w2_opa_q  <= '0;
      cond_q    <= 1'b0;
      depth_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      ctrl_q    <= CTRL_NOP;
      sel_q     <= PC_FROM_INC;
      we_q      <= '0;
      operand_q <= '0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      halt_q    <= halt_d;
      opr_q     <= opr_d;
      opa_q     <= opa_d;
      w2_opr_q  <= w2_opr_d;
      w2_opa_q  <= w2_opa_d;
      cond_q    <= cond_d;
      depth_q   <= depth_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      ctrl_q    <= ctrl_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      operand_q <= operand_d;
    end
  end

  // Next state, then outputs for the phase about to begin (so they register in step with cycle)
  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q + CYC_W'(1);
    halt_d    = halt_q;
    opr_d     = opr_q;
    opa_d     = opa_q;
    w2_opr_d  = w2_opr_q;
    w2_opa_d  = w2_opa_q;
    cond_d    = cond_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ctrl_d    = CTRL_NOP;
    sel_d     = PC_FROM_INC;
    we_d      = '0;
    operand_d = '0;

    case (state_q)
      ST_FETCH1: begin
        if (cycle_q == CYC_W'(3)) opr_d = data;
        if (cycle_q == CYC_W'(4)) opa_d = data;
        if (cycle_q == CYC_W'(7)) begin
          if (two_word) begin
            state_d = ST_FETCH2;
          end else if (is_bbl) begin
            state_d = ST_FLUSH;
          end else if (halt_req) begin
            state_d = ST_HALTED;
            halt_d  = 1'b1;
          end
        end
      end
      ST_FETCH2: begin
        if (cycle_q == CYC_W'(3)) w2_opr_d = data;
        if (cycle_q == CYC_W'(4)) begin
          w2_opa_d = data;
          cond_d   = cond_s;
        end
        if (cycle_q == CYC_W'(7)) begin
          state_d = halt_req ? ST_HALTED : ST_FETCH1;
          halt_d  = halt_req;
        end
      end
      ST_FLUSH: begin
        if (cycle_q == CYC_W'(7)) begin
          state_d = halt_req ? ST_HALTED : ST_FETCH1;
          halt_d  = halt_req;
        end
      end
      ST_HALTED: begin
        cycle_d = '0;
        if (!halt_req) begin
          state_d = ST_FETCH1;
          halt_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_FETCH1;
        cycle_d = '0;
      end
    endcase

    if (state_d == ST_FETCH2) begin
      case (cycle_d)
        CYC_W'(2): if (is_jms) ctrl_d = CTRL_PUSH;
        CYC_W'(5): begin
          if (full_jump) begin
            we_d      = WE_HI;
            operand_d = opa_q;
          end
        end
        CYC_W'(6): begin
          if (full_jump || jcn_taken) begin
            we_d      = WE_MID;
            operand_d = w2_opr_q;
          end
        end
        CYC_W'(7): begin
          if (full_jump || jcn_taken) begin
            we_d      = WE_LO;
            operand_d = w2_opa_q;
          end
        end
        default: ;
      endcase
    end else if (state_d == ST_FLUSH && cycle_d == CYC_W'(2)) begin
      ctrl_d = CTRL_POP;
    end

    if (we_d != '0) sel_d = PC_FROM_INST;

    // Depth mirrors the PC-stack pointer; wrap-around is flagged, flags are sticky
    if (ctrl_d == CTRL_PUSH) begin
      if (depth_q == DEPTH_W'(3)) ovf_d = 1'b1;
      depth_d = depth_q + DEPTH_W'(1);
    end else if (ctrl_d == CTRL_POP) begin
      if (depth_q == DEPTH_W'(0)) unf_d = 1'b1;
      depth_d = depth_q - DEPTH_W'(1);
    end
  end

  assign cycle           = cycle_q;
  assign halt            = halt_q;
  assign control         = ctrl_q;
  assign pc_next_sel     = sel_q;
  assign pc_write_enable = we_q;
  assign inst_operand    = operand_q;
  assign opr             = opr_q;
  assign opa             = opa_q;
  assign stack_ovf       = ovf_q;
  assign stack_unf       = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random instruction stream vs. a per-instruction schedule model.
// Honours PC_SEQ_JCN_EN the same way the design does.
module tb_pc_sequencer;

  localparam logic [1:0] NOP       = 2'd0;
  localparam logic [1:0] PUSH      = 2'd1;
  localparam logic [1:0] POP       = 2'd2;
  localparam logic [1:0] SEL_INST  = 2'd1;

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b0;
  logic       halt_req = 1'b0;
  logic [3:0] data     = 4'h0;
  logic       cond     = 1'b0;
  logic [2:0] cycle;
  logic       halt;
  logic [1:0] control;
  logic [1:0] pc_next_sel;
  logic [2:0] pc_write_enable;
  logic [3:0] inst_operand;
  logic [3:0] opr;
  logic [3:0] opa;
  logic       stack_ovf;
  logic       stack_unf;

  int checks = 0;
  int errors = 0;

  // Model state: stack depth, sticky flags, last latched opcode/operand
  int         m_depth = 0;
  bit         m_ovf   = 1'b0;
  bit         m_unf   = 1'b0;
  logic [3:0] m_opr   = 4'h0;
  logic [3:0] m_opa   = 4'h0;

  pc_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .halt_req       (halt_req),
    .data           (data),
    .cond           (cond),
    .cycle          (cycle),
    .halt           (halt),
    .control        (control),
    .pc_next_sel    (pc_next_sel),
    .pc_write_enable(pc_write_enable),
    .inst_operand   (inst_operand),
    .opr            (opr),
    .opa            (opa),
    .stack_ovf      (stack_ovf),
    .stack_unf      (stack_unf)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time (checks=%0d)", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // 0 single word, 1 JUN, 2 JMS, 3 JCN, 4 BBL
  function automatic int kind_of(input logic [3:0] op);
    case (op)
      4'h4: return 1;
      4'h5: return 2;
      4'hC: return 4;
`ifdef PC_SEQ_JCN_EN
      4'h1: return 3;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, ".cycle"},   12'(cycle),           12'(0));
    chk({tag, ".halt"},    12'(halt),            12'(0));
    chk({tag, ".control"}, 12'(control),         12'(NOP));
    chk({tag, ".we"},      12'(pc_write_enable), 12'(0));
    chk({tag, ".operand"}, 12'(inst_operand),    12'(0));
    chk({tag, ".opr"},     12'(opr),             12'(0));
    chk({tag, ".opa"},     12'(opa),             12'(0));
    chk({tag, ".ovf"},     12'(stack_ovf),       12'(0));
    chk({tag, ".unf"},     12'(stack_unf),       12'(0));
  endtask

  // Called at the falling edge where the instruction's first cycle 0 is visible; returns at the next instruction's cycle 0.
  task automatic do_instr(input logic [7:0] w1, input logic [7:0] w2, input bit c,
                          input bit hreq, input bit rst5);
    int         k;
    int         nwords;
    int         nhalt;
    logic [3:0] prev_opr;
    logic [3:0] prev_opa;
    logic [2:0] e_we;
    logic [3:0] e_op;
    logic [1:0] e_ctl;
    logic [3:0] e_opr;
    logic [3:0] e_opa;
    logic [7:0] word;
    k        = kind_of(w1[7:4]);
    nwords   = (k == 0) ? 1 : 2;
    prev_opr = m_opr;
    prev_opa = m_opa;
    for (int w = 0; w < nwords; w++) begin
      word = (w == 0) ? w1 : w2;
      for (int cyc = 0; cyc < 8; cyc++) begin
        e_we  = 3'b000;
        e_op  = 4'h0;
        e_ctl = NOP;
        if (w == 1) begin
          if (cyc == 2 && k == 2) e_ctl = PUSH;
          if (cyc == 2 && k == 4) e_ctl = POP;
          if (k == 1 || k == 2 || (k == 3 && c)) begin
            if (cyc == 5 && k != 3) begin e_we = 3'b100; e_op = w1[3:0]; end
            if (cyc == 6)           begin e_we = 3'b010; e_op = w2[7:4]; end
            if (cyc == 7)           begin e_we = 3'b001; e_op = w2[3:0]; end
          end
        end
        if (w == 0) begin
          e_opr = (cyc >= 4) ? w1[7:4] : prev_opr;
          e_opa = (cyc >= 5) ? w1[3:0] : prev_opa;
        end else begin
          e_opr = w1[7:4];
          e_opa = w1[3:0];
        end
        chk("cycle",   12'(cycle),           12'(cyc));
        chk("halt",    12'(halt),            12'(0));
        chk("control", 12'(control),         12'(e_ctl));
        chk("we",      12'(pc_write_enable), 12'(e_we));
        chk("opr",     12'(opr),             12'(e_opr));
        chk("opa",     12'(opa),             12'(e_opa));
        if (e_we != 3'b000) begin
          chk("operand", 12'(inst_operand), 12'(e_op));
          chk("sel",     12'(pc_next_sel),  12'(SEL_INST));
        end
        if (!(w == 1 && cyc == 2)) begin
          chk("ovf", 12'(stack_ovf), 12'(m_ovf));
          chk("unf", 12'(stack_unf), 12'(m_unf));
        end
        if (w == 1 && cyc == 2) begin
          if (k == 2) begin
            if (m_depth == 3) m_ovf = 1'b1;
            m_depth = (m_depth + 1) % 4;
          end else if (k == 4) begin
            if (m_depth == 0) m_unf = 1'b1;
            m_depth = (m_depth + 3) % 4;
          end
        end
        if (rst5 && w == 1 && cyc == 5) begin
          #2 reset_n = 1'b0;
          #1 check_reset_vals("async_rst");
          m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0; m_opr = 4'h0; m_opa = 4'h0;
          halt_req = 1'b0;
          @(posedge clock);
          @(negedge clock);
          check_reset_vals("held_rst");
          reset_n = 1'b1;
          return;
        end
        if (cyc == 3)      data = word[7:4];
        else if (cyc == 4) data = word[3:0];
        else               data = 4'($urandom);
        cond     = (w == 1 && cyc == 4) ? c : ~c;
        halt_req = (cyc == 7 && w == nwords - 1) ? hreq : 1'($urandom);
        @(negedge clock);
      end
      if (w == 0) begin
        m_opr = w1[7:4];
        m_opa = w1[3:0];
      end
    end
    if (hreq) begin
      nhalt = int'($urandom_range(1, 4));
      for (int i = 0; i < nhalt; i++) begin
        chk("halted.cycle",   12'(cycle),           12'(0));
        chk("halted.halt",    12'(halt),            12'(1));
        chk("halted.control", 12'(control),         12'(NOP));
        chk("halted.we",      12'(pc_write_enable), 12'(0));
        chk("halted.opr",     12'(opr),             12'(m_opr));
        data = 4'($urandom);
        cond = 1'($urandom);
        if (i == nhalt - 1) halt_req = 1'b0;
        @(negedge clock);
      end
    end
  endtask

  initial begin
    logic [3:0] op;
    logic [7:0] w2r;
    repeat (2) @(negedge clock);
    check_reset_vals("por");
    reset_n = 1'b1;

    // JUN 0x4A 0x3C: writes A,3,C
    do_instr(8'h4A, 8'h3C, 1'b0, 1'b0, 1'b0);
    // JMS 0x52 0x10 then BBL back to depth 0
    do_instr(8'h52, 8'h10, 1'b0, 1'b0, 1'b0);
    do_instr(8'hC0, 8'h00, 1'b0, 1'b0, 1'b0);
    // Five nested JMS: overflow on the fourth push; two BBLs reach depth 0 then underflow
    for (int i = 0; i < 5; i++) do_instr({4'h5, 4'($urandom)}, 8'($urandom), 1'b0, 1'b0, 1'b0);
    do_instr(8'hC1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    do_instr(8'hC2, 8'($urandom), 1'b0, 1'b0, 1'b0);
    // Halt requested during a JUN's second word
    do_instr(8'h47, 8'h9E, 1'b0, 1'b1, 1'b0);
    do_instr(8'hD3, 8'h00, 1'b0, 1'b0, 1'b0);
    // JCN with cond 0 and 1
    do_instr(8'h10, 8'h57, 1'b0, 1'b0, 1'b0);
    do_instr(8'h10, 8'h57, 1'b1, 1'b0, 1'b0);
    // Reset during FETCH2 cycle 5, then a plain instruction must make no writes
    do_instr(8'h4A, 8'h3C, 1'b0, 1'b0, 1'b1);
    do_instr(8'hD3, 8'h00, 1'b0, 1'b0, 1'b0);
    do_instr(8'h5B, 8'h21, 1'b0, 1'b0, 1'b1);
    do_instr(8'h2F, 8'h00, 1'b0, 1'b1, 1'b0);

    // Random instruction stream biased toward control-flow opcodes
    for (int i = 0; i < 160; i++) begin
      case ($urandom_range(0, 7))
        0: op = 4'h1;
        1: op = 4'h4;
        2: op = 4'h5;
        3: op = 4'hC;
        default: op = 4'($urandom);
      endcase
      w2r = 8'($urandom);
      do_instr({op, 4'($urandom)}, w2r, 1'($urandom), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
